// File: rtl/nios_pio_edge_debounce.sv
// Avalon-MM input PIO: per-channel synchroniser, tick-based debounce, edge capture
// into a write-1-to-clear register, and a maskable level interrupt.
module nios_pio_edge_debounce #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned DB_W          = 16,
    parameter int unsigned STABLE_N      = 4,
    parameter int unsigned DB_PERIOD_RST = 49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DB_W-1:0] PeriodRst = DB_W'(DB_PERIOD_RST);
    localparam logic [3:0]      CntLast   = 4'(STABLE_N - 1);

    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   db_q, db_d, db_dly_q;
    logic [3:0]         cnt_q [WIDTH];
    logic [3:0]         cnt_d [WIDTH];
    logic [2*WIDTH-1:0] mode_q;
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   cap_q, cap_d;
    logic [DB_W-1:0]    period_q;
    logic [DB_W-1:0]    pc_q, pc_d;
    logic [31:0]        readdata_d;
    logic [WIDTH-1:0]   rise, fall, ev, clr;
    logic               wr, tick;
    logic               unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign tick             = (pc_q == '0);
    assign unused_writedata = ^writedata;

    always_comb begin
        pc_d = pc_q - DB_W'(1);
        if (wr && address == 3'd4) begin
            pc_d = writedata[DB_W-1:0];
        end else if (tick) begin
            pc_d = period_q;
        end
    end

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == CntLast) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign rise = db_q & ~db_dly_q;
    assign fall = ~db_q & db_dly_q;

    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_q[2*i +: 2])
                2'b01:   ev[i] = rise[i];
                2'b10:   ev[i] = fall[i];
                2'b11:   ev[i] = rise[i] | fall[i];
                default: ev[i] = 1'b0;
            endcase
        end
    end

    // A new event wins over a simultaneous clear of the same bit.
    assign clr   = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    assign cap_d = (cap_q & ~clr) | ev;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0]   = db_q;
            3'd1:    readdata_d[2*WIDTH-1:0] = mode_q;
            3'd2:    readdata_d[WIDTH-1:0]   = mask_q;
            3'd3:    readdata_d[WIDTH-1:0]   = cap_q;
            3'd4:    readdata_d[DB_W-1:0]    = period_q;
            3'd5:    readdata_d[WIDTH-1:0]   = sync2_q;
            default: readdata_d              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= 4'd0;
            mode_q   <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            period_q <= PeriodRst;
            pc_q     <= PeriodRst;
            readdata <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            cap_q    <= cap_d;
            pc_q     <= pc_d;
            readdata <= readdata_d;
            if (wr) begin
                case (address)
                    3'd1:    mode_q   <= writedata[2*WIDTH-1:0];
                    3'd2:    mask_q   <= writedata[WIDTH-1:0];
                    3'd4:    period_q <= writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Driven only from flops so in_port cannot glitch the interrupt.
    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_edge_debounce.sv
// Directed bench for nios_pio_edge_debounce: register map, debounce timing,
// edge modes, capture clear priority, prescaler and asynchronous reset.
module tb_nios_pio_edge_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    nios_pio_edge_debounce #(
        .WIDTH        (4),
        .DB_W         (16),
        .STABLE_N     (4),
        .DB_PERIOD_RST(49999)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step(1);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] exp_rd [8];
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000C34F, 32'h0, 32'h0, 32'h0};
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            vectors++;
            if (d !== exp_rd[a]) begin
                miscompares++;
                $display("FAIL reset_read addr %0d: got %h want %h", a, d, exp_rd[a]);
            end
        end
    endtask

    task automatic test_rising;
        logic [31:0] d;
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h1);
        in_port = 4'b0001;
        step(6);  // just after t+5
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_irq_early: got %b want 0", irq);
        end
        step(1);  // just after t+6
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL rise_irq_t6: got %b want 1", irq);
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL rise_data: got %h want 1", d);
        end
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL rise_capture: got %h want 1", d);
        end
        bus_write(3'd3, 32'h1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_clear_irq: got %b want 0", irq);
        end
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL rise_clear_cap: got %h want 0", d);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        bus_write(3'd1, 32'h05);
        address = 3'd5;
        in_port = 4'b0011;
        step(3);
        vectors++;
        if (readdata !== 32'h3) begin
            miscompares++;
            $display("FAIL glitch_raw: got %h want 3", readdata);
        end
        in_port = 4'b0001;
        step(10);
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL glitch_data: got %h want 1", d);
        end
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_capture: got %h want 0", d);
        end
        in_port = 4'b0011;
        step(4);
        in_port = 4'b0001;
        step(12);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL pulse4_capture: got %h want 2", d);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse4_irq_masked: got %b want 0", irq);
        end
    endtask

    task automatic test_modes;
        logic [31:0] d;
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h0);
        in_port = 4'b0000;
        step(10);
        bus_write(3'd3, 32'hF);
        bus_write(3'd1, 32'hE0);
        in_port = 4'b1100;
        step(10);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h8) begin
            miscompares++;
            $display("FAIL modes_rise: got %h want 8", d);
        end
        in_port = 4'b0000;
        step(10);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'hC) begin
            miscompares++;
            $display("FAIL modes_fall: got %h want c", d);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL modes_irq_mask0: got %b want 0", irq);
        end
        bus_write(3'd2, 32'h4);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL modes_irq_mask4: got %b want 1", irq);
        end
        bus_write(3'd3, 32'hF);
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'h0);
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        bus_write(3'd1, 32'h05);
        in_port = 4'b0011;
        step(10);
        in_port = 4'b0000;
        step(10);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h3) begin
            miscompares++;
            $display("FAIL simul_setup: got %h want 3", d);
        end
        in_port = 4'b0001;
        step(6);
        bus_write(3'd3, 32'h3);  // lands on the edge where ch0 event is captured
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL simul_event_wins: got %h want 1", d);
        end
        in_port = 4'b0011;
        step(10);
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL simul_clear_bit1: got %h want 1", d);
        end
        bus_write(3'd1, 32'h0);
        in_port = 4'b0000;
        step(10);
        bus_write(3'd3, 32'hF);
    endtask

    task automatic test_prescaler_reset;
        logic [31:0] d;
        bus_write(3'd1, 32'h10);
        bus_write(3'd2, 32'h4);
        bus_write(3'd4, 32'd9);
        in_port = 4'b0100;
        step(39);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL presc_early: got %b want 0", irq);
        end
        step(3);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL presc_accept: got %b want 1", irq);
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h4) begin
            miscompares++;
            $display("FAIL presc_data: got %h want 4", d);
        end
        in_port = 4'b0000;
        step(15);
        vectors++;
        if (readdata !== 32'h4) begin
            miscompares++;
            $display("FAIL presc_midcount_data: got %h want 4", readdata);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: irq %b readdata %h want 0 0", irq, readdata);
        end
        step(2);
        reset_n = 1'b1;
        bus_read(3'd4, d);
        vectors++;
        if (d !== 32'h0000C34F) begin
            miscompares++;
            $display("FAIL reset_period: got %h want c34f", d);
        end
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'h10);
        bus_write(3'd2, 32'h4);
        step(10);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_no_event: cap %h irq %b want 0 0", d, irq);
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL post_reset_data: got %h want 0", d);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'b0000;
        step(3);
        reset_n = 1'b1;
        test_reset();
        test_rising();
        test_glitch();
        test_modes();
        test_simultaneous();
        test_prescaler_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
